rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (rf_wen / rf_addr_w / rf_data_w, 32 x 32-bit, written on the falling clock edge) between two write-back requesters: port 0 (ALU) and port 1 (load unit).
- Arbitration is fixed priority to port 0, with an aging counter that guarantees port 1 forward progress.
- The winning write goes into a one-entry output register that drives the register-file write port directly.
- An external hold input can stall the write port.

Parameters:
- MAX_WAIT, 4: number of consecutive cycles port 1 may be refused before it overrides port 0. Legal range is 1..15.
- R0_WRITABLE, 0: when 0, writes to address 0 are accepted and silently discarded. When 1, they are written.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req0_valid  input  1  port 0 has a write-back pending.
- req0_addr  input  5  port 0 destination register.
- req0_data  input  32  port 0 write data.
- req0_ready  output  1  port 0 write accepted this cycle.
- req1_valid  input  1  port 1 has a write-back pending.
- req1_addr  input  5  port 1 destination register.
- req1_data  input  32  port 1 write data.
- req1_ready  output  1  port 1 write accepted this cycle.
- rf_hold  input  1  register file must not be written this cycle.
- rf_wen  output  1  register-file write enable.
- rf_addr_w  output  5  register-file write address.
- rf_data_w  output  32  register-file write data.
- wait_cnt  output  4  current port 1 aging count (debug / verification visibility).

Behaviour:
- Reset state (async, resetn low):
  - out_v=0, rf_addr_w=0, rf_data_w=0, wait_cnt=0.
  - rf_wen=0, req0_ready=0, req1_ready=0 while resetn is low.
- Write port:
  - rf_wen = out_v & ~rf_hold (combinational).
  - rf_addr_w and rf_data_w are the output register contents.
  - Address/data are stable for the whole cycle, so the falling-edge register file samples the held values.
- Slot free: slot_free = ~out_v | ~rf_hold. The output register either is empty or is draining this cycle.
- Grant (combinational, only when slot_free and resetn high):
  - If req1_valid & wait_cnt==MAX_WAIT: grant port 1.
  - Else if req0_valid: grant port 0.
  - Else if req1_valid: grant port 1.
  - Else: no grant.
- Ready outputs: reqN_ready = grant_N. A transfer occurs on a rising edge where valid & ready are both high.
- Requester rule: requesters hold valid/addr/data stable until ready. The arbiter does not check this.
- Output register update at the rising edge:
  - On a grant: load the granted addr/data. out_v=1, except when addr==0 and R0_WRITABLE==0, in which case out_v=0 (write dropped, requester still sees ready).
  - On no grant, if slot_free: out_v=0.
  - Otherwise (held): all output-register contents are unchanged.
- Latency: a write accepted at rising edge k drives rf_wen during cycle k+1 if rf_hold=0. The register file commits it at the falling edge inside cycle k+1. Sustained throughput is 1 write/cycle.
- Aging counter wait_cnt:
  - Increments (saturating at MAX_WAIT) on each edge where req1_valid=1 and req1_ready=0.
  - Clears on a port 1 transfer or when req1_valid=0.
  - Is not incremented while slot_free=0 (no arbitration took place).
- Simultaneous same address: both writes are serialized. The later-granted write lands last and wins; no merging.
- Hold: while rf_hold=1 and out_v=1, both readies are 0 and the entry persists indefinitely. rf_hold with out_v=0 has no effect on acceptance.
- Reset mid-operation: a pending output entry is lost and rf_wen drops immediately (asynchronously). Requesters must re-present.

Test Plan:
- Reset: assert resetn=0 mid-stream with out_v=1 → rf_wen, req0_ready and req1_ready go 0 immediately. After release, wait_cnt=0 and the first accepted write appears one cycle later.
- Single port: req0 writes addr 5=32'hDEADBEEF at edge k → rf_wen=1, rf_addr_w=5, rf_data_w=DEADBEEF in cycle k+1. Register 5 reads DEADBEEF after that cycle's falling edge.
- Starvation: req0_valid held high continuously, req1 requests addr 7=32'h1234, MAX_WAIT=4 → port 0 is granted for 4 cycles, with wait_cnt stepping 1..4. Port 1 is granted on the 5th cycle and wait_cnt returns to 0.
- Hold:
  - Step 1: accept addr 3=32'hA, then rf_hold=1 for 3 cycles with req0 valid for addr 4=32'hB → rf_wen=0 and ready=0 for those 3 cycles.
  - Step 2: in the first cycle after rf_hold=0 → addr 3 is written and addr 4 is accepted in the same cycle.
- Zero register: R0_WRITABLE=0, req0 writes addr 0=32'hFFFFFFFF → req0_ready=1, rf_wen stays 0 and register 0 remains 0. With R0_WRITABLE=1 → rf_wen=1, rf_addr_w=0.
- Same address collision: req0 and req1 both write addr 9 (32'h1 and 32'h2) in the same cycle, wait_cnt=0 → port 0 is written first, port 1 next cycle. Register 9 ends at 32'h2.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_if
//   Bundles the two write-back request channels, the register-file write
//   port and the aging debug count that surround rf_wb_arbiter.
//
//   Handshake: a requester raises reqN_valid with reqN_addr/reqN_data and
//   keeps all three stable until it sees reqN_ready. A transfer happens on
//   every rising clock edge where reqN_valid and reqN_ready are both high.
//   reqN_ready is combinational and never waits on a later valid.
//
//   Modports:
//     slave  - the arbiter: consumes requests and rf_hold, drives readies,
//              the register-file write port and wait_cnt.
//     master - the surrounding pipeline/register file (or a testbench).
// ---------------------------------------------------------------------------
interface rf_wb_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;

    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;

    logic        rf_hold;
    logic        rf_wen;
    logic [4:0]  rf_addr_w;
    logic [31:0] rf_data_w;

    logic [3:0]  wait_cnt;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rf_hold,
        output req0_ready, req1_ready,
        output rf_wen, rf_addr_w, rf_data_w,
        output wait_cnt
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rf_hold,
        input  req0_ready, req1_ready,
        input  rf_wen, rf_addr_w, rf_data_w,
        input  wait_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single register-file write port between port 0 (ALU) and
//   port 1 (load unit). Port 0 has fixed priority; an aging counter lets
//   port 1 override after MAX_WAIT consecutive refusals. The winning write
//   sits in a one-entry output register that drives the write port.
//
//   Parameters:
//     MAX_WAIT    - refusals port 1 tolerates before overriding (1..15).
//     R0_WRITABLE - 0: writes to x0 are acknowledged and discarded.
//
//   Ports:
//     clk    - rising-edge clock.
//     resetn - asynchronous active-low reset.
//     bus    - rf_wb_arbiter_if.slave: requests, readies, write port,
//              rf_hold stall input and wait_cnt debug count.
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int unsigned MAX_WAIT    = 4,
    parameter bit          R0_WRITABLE = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,
    rf_wb_arbiter_if.slave     bus
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic        out_v_q,  out_v_d;
    logic [4:0]  addr_q,   addr_d;
    logic [31:0] data_q,   data_d;
    logic [3:0]  wait_q,   wait_d;

    logic        slot_free;
    logic        wait_full;
    logic        grant0;
    logic        grant1;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    always_comb begin
        // The entry is either empty or leaves this cycle, so a new one fits.
        slot_free = ~out_v_q | ~bus.rf_hold;
        wait_full = (wait_q == MAX_WAIT_C);

        grant0 = 1'b0;
        grant1 = 1'b0;
        if (resetn && slot_free) begin
            if (bus.req1_valid && wait_full) begin
                grant1 = 1'b1;
            end else if (bus.req0_valid) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end

        sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
        sel_data = grant1 ? bus.req1_data : bus.req0_data;
    end

    always_comb begin
        out_v_d = out_v_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (grant0 || grant1) begin
            addr_d  = sel_addr;
            data_d  = sel_data;
            // A write to x0 is acknowledged but never reaches the port.
            out_v_d = (sel_addr != 5'd0) || R0_WRITABLE;
        end else if (slot_free) begin
            out_v_d = 1'b0;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!bus.req1_valid || grant1) begin
            wait_d = 4'd0;
        end else if (slot_free && !wait_full) begin
            // Only a real arbitration round that refused port 1 ages it.
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_v_q <= 1'b0;
            addr_q  <= 5'd0;
            data_q  <= 32'd0;
            wait_q  <= 4'd0;
        end else begin
            out_v_q <= out_v_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
        end
    end

    // out_v_q clears asynchronously, so rf_wen drops the moment reset asserts.
    assign bus.rf_wen     = out_v_q & ~bus.rf_hold;
    assign bus.rf_addr_w  = addr_q;
    assign bus.rf_data_w  = data_q;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.wait_cnt   = wait_q;

endmodule
